// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
// UART transmit controller and serializer. Accepts a parallel word on a valid
// strobe and sequences a start / data (LSB first) / optional parity / stop
// frame, one bit per CLK, feeding a downstream registered TX output mux.
//
// Ports:
//   CLK         in   1           baud-rate clock, rising edge
//   RST         in   1           asynchronous, active-low reset
//   P_DATA      in   DATA_WIDTH  parallel payload, sampled on accept
//   Data_Valid  in   1           payload valid strobe, honoured only in IDLE
//   PAR_EN      in   1           1 = insert parity bit, sampled on accept
//   PAR_TYP     in   1           0 = even, 1 = odd, sampled on accept
//   SER_Data    out  1           current serial data bit (shift_reg[0])
//   PAR_Bit     out  1           parity of the latched payload
//   Mux_Sel     out  2           00 start, 01 idle/stop, 10 data, 11 parity
//   Busy        out  1           1 while a frame is in progress
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  SER_Data,
  output logic                  PAR_Bit,
  output logic [1:0]            Mux_Sel,
  output logic                  Busy
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CW-1:0]         bit_cnt;
  logic                  par_en_q;
  logic                  last_bit;

  assign last_bit = (bit_cnt == CW'(DATA_WIDTH - 1));
  assign SER_Data = shift_reg[0];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  // Next state and Moore outputs; unused encodings fall back to IDLE.
  always_comb begin
    next_state = IDLE;
    Mux_Sel    = 2'b01;
    Busy       = 1'b0;
    case (state)
      IDLE: begin
        next_state = Data_Valid ? START : IDLE;
      end
      START: begin
        Mux_Sel    = 2'b00;
        Busy       = 1'b1;
        next_state = DATA;
      end
      DATA: begin
        Mux_Sel = 2'b10;
        Busy    = 1'b1;
        if (last_bit) next_state = par_en_q ? PARITY : STOP;
        else          next_state = DATA;
      end
      PARITY: begin
        Mux_Sel    = 2'b11;
        Busy       = 1'b1;
        next_state = STOP;
      end
      STOP: begin
        Mux_Sel    = 2'b01;
        Busy       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath. The counter holds on the last data bit rather than wrapping,
  // so it never overflows its $clog2 width within a frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      par_en_q  <= 1'b0;
      PAR_Bit   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Data_Valid) begin
            shift_reg <= P_DATA;
            par_en_q  <= PAR_EN;
            PAR_Bit   <= PAR_TYP ? ~^P_DATA : ^P_DATA;
          end
        end
        START: begin
          bit_cnt <= '0;
        end
        DATA: begin
          shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
          if (!last_bit) bit_cnt <= bit_cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl
// Self-checking bench for uart_tx_ctrl: a frame-level reference model
// (frame position counter over the latched payload) is compared against the
// DUT outputs every cycle, plus directed frames pinned to literal values.
module tb_uart_tx_ctrl;

  localparam int W = 8;

  logic         CLK;
  logic         RST;
  logic [W-1:0] P_DATA;
  logic         Data_Valid;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic         SER_Data;
  logic         PAR_Bit;
  logic [1:0]   Mux_Sel;
  logic         Busy;

  int tests_run = 0;
  int failures  = 0;

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .SER_Data   (SER_Data),
    .PAR_Bit    (PAR_Bit),
    .Mux_Sel    (Mux_Sel),
    .Busy       (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Downstream registered TX mux.
  logic tx_line;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) tx_line <= 1'b1;
    else begin
      case (Mux_Sel)
        2'b00:   tx_line <= 1'b0;
        2'b01:   tx_line <= 1'b1;
        2'b10:   tx_line <= SER_Data;
        default: tx_line <= PAR_Bit;
      endcase
    end
  end

  // Reference model: a frame is a position index 0..len-1 over the payload
  // captured at accept.
  logic         m_in_frame;
  int           m_pos;
  logic [W-1:0] m_data;
  logic         m_par_en;
  logic         m_par;
  logic         m_line;
  logic [1:0]   e_mux;
  logic         e_busy;
  logic         e_ser;
  logic         e_line_next;

  function automatic logic parity_of(input logic [W-1:0] d, input logic odd);
    int ones;
    ones = 0;
    for (int i = 0; i < W; i++) ones += int'(d[i]);
    return ((ones % 2) == 1) ^ odd;
  endfunction

  always_comb begin
    e_mux  = 2'b01;
    e_busy = 1'b0;
    e_ser  = 1'b0;
    if (m_in_frame) begin
      e_busy = 1'b1;
      if (m_pos == 0) begin
        e_mux = 2'b00;
        e_ser = m_data[0];
      end else if (m_pos <= W) begin
        e_mux = 2'b10;
        e_ser = m_data[m_pos-1];
      end else if (m_par_en && m_pos == W + 1) begin
        e_mux = 2'b11;
      end
    end
    case (e_mux)
      2'b00:   e_line_next = 1'b0;
      2'b01:   e_line_next = 1'b1;
      2'b10:   e_line_next = e_ser;
      default: e_line_next = m_par;
    endcase
  end

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_in_frame <= 1'b0;
      m_pos      <= 0;
      m_data     <= '0;
      m_par_en   <= 1'b0;
      m_par      <= 1'b0;
      m_line     <= 1'b1;
    end else begin
      m_line <= e_line_next;
      if (m_in_frame) begin
        if (m_pos == W + 1 + int'(m_par_en)) m_in_frame <= 1'b0;
        else                                  m_pos      <= m_pos + 1;
      end else if (Data_Valid) begin
        m_in_frame <= 1'b1;
        m_pos      <= 0;
        m_data     <= P_DATA;
        m_par_en   <= PAR_EN;
        m_par      <= parity_of(P_DATA, PAR_TYP);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Continuous comparison against the model.
  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      checkOutput("model Mux_Sel", 32'(Mux_Sel), 32'(e_mux));
      checkOutput("model Busy", 32'(Busy), 32'(e_busy));
      checkOutput("model SER_Data", 32'(SER_Data), 32'(e_ser));
      checkOutput("model PAR_Bit", 32'(PAR_Bit), 32'(m_par));
      checkOutput("model tx_line", 32'(tx_line), 32'(m_line));
    end
  end

  task automatic applyStimulus(input logic [W-1:0] d, input logic v,
                               input logic pe, input logic pt);
    P_DATA     = d;
    Data_Valid = v;
    PAR_EN     = pe;
    PAR_TYP    = pt;
  endtask

  // Called at a negedge; skips idle cycles then records one frame, returning
  // at the negedge of the first idle cycle after it.
  task automatic collectFrame(output int idle_before, output int busy_cycles,
                              output int data_cycles, output logic [W-1:0] bits,
                              output int par_cycles, output logic par_val,
                              output logic [1:0] first_mux, output logic [1:0] last_mux,
                              output logic line_first, output logic line_second);
    idle_before = 0; busy_cycles = 0; data_cycles = 0; bits = '0;
    par_cycles = 0; par_val = 1'b0; first_mux = 2'b01; last_mux = 2'b01;
    line_first = 1'b0; line_second = 1'b0;
    while (!Busy && idle_before < 20) begin
      idle_before++;
      @(negedge CLK);
    end
    if (!Busy) checkOutput("frame start timeout", 32'(Busy), 32'd1);
    while (Busy && busy_cycles < 40) begin
      if (busy_cycles == 0) begin
        first_mux  = Mux_Sel;
        line_first = tx_line;
      end
      if (busy_cycles == 1) line_second = tx_line;
      if (Mux_Sel == 2'b10) begin
        if (data_cycles < W) bits[data_cycles] = SER_Data;
        data_cycles++;
      end
      if (Mux_Sel == 2'b11) par_cycles++;
      par_val  = PAR_Bit;
      last_mux = Mux_Sel;
      busy_cycles++;
      @(negedge CLK);
    end
    if (Busy) checkOutput("frame end timeout", 32'(Busy), 32'd0);
  endtask

  int           ib, bc, dc, pc;
  logic [W-1:0] bits;
  logic         pv, lf, ls;
  logic [1:0]   fm, lm;

  initial begin
    RST = 1'b0;
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    checkOutput("reset Mux_Sel", 32'(Mux_Sel), 32'h1);
    checkOutput("reset Busy", 32'(Busy), 32'h0);
    checkOutput("reset SER_Data", 32'(SER_Data), 32'h0);
    checkOutput("reset PAR_Bit", 32'(PAR_Bit), 32'h0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // Even parity, 8'hA5.
    applyStimulus(8'hA5, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    applyStimulus(8'hA5, 1'b0, 1'b1, 1'b0);
    collectFrame(ib, bc, dc, bits, pc, pv, fm, lm, lf, ls);
    checkOutput("A5 data bits", 32'(bits), 32'hA5);
    checkOutput("A5 data cycles", 32'(dc), 32'd8);
    checkOutput("A5 busy cycles", 32'(bc), 32'd11);
    checkOutput("A5 parity cycles", 32'(pc), 32'd1);
    checkOutput("A5 PAR_Bit", 32'(pv), 32'd0);
    checkOutput("A5 first Mux_Sel", 32'(fm), 32'h0);
    checkOutput("A5 stop Mux_Sel", 32'(lm), 32'h1);
    checkOutput("A5 line before start", 32'(lf), 32'd1);
    checkOutput("A5 line start bit", 32'(ls), 32'd0);
    checkOutput("A5 line idle", 32'(tx_line), 32'd1);

    // No parity, 8'h01.
    @(negedge CLK);
    applyStimulus(8'h01, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    applyStimulus(8'h01, 1'b0, 1'b0, 1'b0);
    collectFrame(ib, bc, dc, bits, pc, pv, fm, lm, lf, ls);
    checkOutput("01 data bits", 32'(bits), 32'h01);
    checkOutput("01 busy cycles", 32'(bc), 32'd10);
    checkOutput("01 parity cycles", 32'(pc), 32'd0);
    checkOutput("01 stop Mux_Sel", 32'(lm), 32'h1);

    // Odd and even parity of 8'h07.
    @(negedge CLK);
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b1);
    @(negedge CLK);
    applyStimulus(8'h07, 1'b0, 1'b1, 1'b1);
    collectFrame(ib, bc, dc, bits, pc, pv, fm, lm, lf, ls);
    checkOutput("07 odd PAR_Bit", 32'(pv), 32'd0);
    @(negedge CLK);
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    applyStimulus(8'h07, 1'b0, 1'b1, 1'b0);
    collectFrame(ib, bc, dc, bits, pc, pv, fm, lm, lf, ls);
    checkOutput("07 even PAR_Bit", 32'(pv), 32'd1);

    // Back-to-back with mid-frame input changes.
    @(negedge CLK);
    applyStimulus(8'h3C, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    fork
      collectFrame(ib, bc, dc, bits, pc, pv, fm, lm, lf, ls);
      begin
        repeat (3) @(negedge CLK);
        applyStimulus(8'hC3, 1'b1, 1'b0, 1'b0);
      end
    join
    checkOutput("b2b frame1 bits", 32'(bits), 32'h3C);
    checkOutput("b2b frame1 busy", 32'(bc), 32'd11);
    checkOutput("b2b frame1 parity", 32'(pc), 32'd1);
    collectFrame(ib, bc, dc, bits, pc, pv, fm, lm, lf, ls);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("b2b idle gap", 32'(ib), 32'd1);
    checkOutput("b2b frame2 bits", 32'(bits), 32'hC3);
    checkOutput("b2b frame2 busy", 32'(bc), 32'd10);
    checkOutput("b2b frame2 parity", 32'(pc), 32'd0);

    // Asynchronous reset in the third data cycle.
    repeat (2) @(negedge CLK);
    applyStimulus(8'hFF, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    applyStimulus(8'hFF, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge CLK);
    checkOutput("pre-reset Mux_Sel", 32'(Mux_Sel), 32'h2);
    #2 RST = 1'b0;
    #1;
    checkOutput("async reset Mux_Sel", 32'(Mux_Sel), 32'h1);
    checkOutput("async reset Busy", 32'(Busy), 32'h0);
    checkOutput("async reset SER_Data", 32'(SER_Data), 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checkOutput("post-reset Busy", 32'(Busy), 32'h0);
      checkOutput("post-reset Mux_Sel", 32'(Mux_Sel), 32'h1);
    end

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      applyStimulus(W'($urandom), ($urandom_range(0, 3) == 0),
                    1'($urandom), 1'($urandom));
      if ($urandom_range(0, 99) == 0) begin
        #2 RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
      end
    end
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    repeat (15) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
